// File: rtl/itch_msg_framer_pkg.sv
// Shared types and constants for the ITCH message framer.
// Imported by the framer top and its byte aligner.
package itch_msg_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_BODY,
    ST_DRAIN
  } framer_state_t;

  localparam int HDR_BYTES     = 64;
  localparam int BEAT_BYTES    = 8;
  localparam int LEN_PFX_BYTES = 2;

  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
    return (n > 4'(BEAT_BYTES)) ? 4'(BEAT_BYTES) : n;
  endfunction

endpackage

// File: rtl/itch_msg_framer_if.sv
// Frame-word input stream into the framer, with the decoder's messageCount alongside.
// master drives frame words; slave (the framer) returns in_ready.
interface itch_msg_framer_if;
  logic        in_valid;
  logic        in_sop;
  logic        in_last;
  logic [3:0]  in_nbytes;
  logic [63:0] in_data;
  logic [15:0] msg_count;
  logic        in_ready;

  modport master (
    output in_valid, in_sop, in_last, in_nbytes, in_data, msg_count,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sop, in_last, in_nbytes, in_data, msg_count,
    output in_ready
  );
endinterface

// File: rtl/itch_msg_framer_aligner.sv
// 16-byte shift buffer: pops 0..8 bytes from the head and appends up to 8 bytes behind
// what remains, in the same cycle. Bytes above the occupancy are kept at zero.
module itch_msg_framer_aligner
  import itch_msg_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [3:0]  push_n,
  input  logic [63:0] push_data,
  input  logic [3:0]  pop_n,
  output logic [63:0] head,
  output logic [4:0]  occ
);

  logic [127:0] store_q;
  logic [4:0]   occ_q;
  logic [63:0]  data_m;
  logic [127:0] shifted;
  logic [127:0] incoming;
  logic [4:0]   base;

  always_comb begin
    data_m = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (4'(i) < push_n) data_m[8*i +: 8] = push_data[8*i +: 8];
    end
    shifted  = store_q >> {pop_n, 3'b000};
    base     = occ_q - {1'b0, pop_n};
    incoming = {64'd0, data_m} << {base, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= '0;
      occ_q   <= '0;
    end else if (clear) begin
      store_q <= '0;
      occ_q   <= '0;
    end else begin
      store_q <= shifted | (push ? incoming : 128'd0);
      occ_q   <= base + (push ? {1'b0, push_n} : 5'd0);
    end
  end

  assign head = store_q[63:0];
  assign occ  = occ_q;

endmodule

// File: rtl/itch_msg_framer.sv
// Splits the MoldUDP64 payload of each frame into byte-realigned ITCH message beats.
// Header words are dropped; each 2-byte big-endian length prefix is stripped.
//
// state    | meaning
// ST_IDLE  | waiting for a start-of-frame word
// ST_HDR   | dropping header words
// ST_LEN   | waiting for / consuming the 2-byte length prefix
// ST_BODY  | emitting message beats until the length is exhausted
// ST_DRAIN | discarding the rest of the frame
module itch_msg_framer
  import itch_msg_framer_pkg::*;
#(
  parameter int          HDR_WORDS   = HDR_BYTES / BEAT_BYTES,
  parameter logic [15:0] MAX_MSG_LEN = 16'd512
) (
  input  logic                 clk,
  input  logic                 rst,
  itch_msg_framer_if.slave     bus,
  output logic                 msg_valid,
  output logic                 msg_sop,
  output logic                 msg_eop,
  output logic [3:0]           msg_nbytes,
  output logic [63:0]          msg_data,
  output logic [15:0]          msg_len,
  output logic [15:0]          msg_idx,
  output logic                 err_trunc,
  output logic                 err_len,
  output logic                 frame_done
);

  localparam logic [7:0] HDR_LAST = 8'(HDR_WORDS - 1);

  framer_state_t state;
  logic [7:0]  hdr_cnt;
  logic        first_pay, last_seen, first_beat, done_pend;
  logic [15:0] cnt_q, len_q, rem, idx;

  logic        accept, start, push, clear, parse, beat, beat_eop, trunc;
  logic        end_nobeat, end_beat, bad_len;
  logic [3:0]  pop_n, beat_n, want, push_n;
  logic [4:0]  occ;
  logic [63:0] head, beat_data;
  logic [15:0] pfx;

  itch_msg_framer_aligner u_aligner (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_n    (push_n),
    .push_data (bus.in_data),
    .pop_n     (pop_n),
    .head      (head),
    .occ       (occ)
  );

  // No new words once the frame's last word is in; the tail drains first.
  assign bus.in_ready = !last_seen && (occ <= 5'(BEAT_BYTES));
  assign accept       = bus.in_valid && bus.in_ready;
  assign start        = accept && bus.in_sop;
  assign push_n       = clamp_nbytes(bus.in_nbytes);
  assign pfx          = {head[7:0], head[15:8]};
  assign bad_len      = (pfx == 16'd0) || (pfx > MAX_MSG_LEN);
  assign want         = (rem > 16'(BEAT_BYTES)) ? 4'(BEAT_BYTES) : rem[3:0];

  always_comb begin
    pop_n      = '0;
    clear      = 1'b0;
    parse      = 1'b0;
    beat       = 1'b0;
    beat_n     = '0;
    beat_eop   = 1'b0;
    trunc      = 1'b0;
    end_nobeat = 1'b0;
    end_beat   = 1'b0;
    if (start) begin
      clear      = 1'b1;
      end_nobeat = bus.in_last;
      trunc      = (state == ST_BODY) || (state == ST_LEN && occ != 5'd0);
    end else begin
      case (state)
        ST_HDR: end_nobeat = accept && bus.in_last;
        ST_LEN: begin
          if (last_seen && occ < 5'(LEN_PFX_BYTES)) begin
            end_nobeat = 1'b1;
            trunc      = (occ != 5'd0);
            clear      = 1'b1;
          end else if (occ >= 5'(LEN_PFX_BYTES)) begin
            parse = 1'b1;
            pop_n = 4'(LEN_PFX_BYTES);
          end
        end
        ST_BODY: begin
          if (occ >= {1'b0, want}) begin
            beat     = 1'b1;
            beat_n   = want;
            pop_n    = want;
            beat_eop = (rem == {12'd0, want});
          end else if (last_seen) begin
            // Frame ended mid-message: whatever is held goes out as a short final beat.
            beat       = (occ != 5'd0);
            beat_n     = occ[3:0];
            pop_n      = occ[3:0];
            beat_eop   = 1'b1;
            trunc      = 1'b1;
            end_beat   = (occ != 5'd0);
            end_nobeat = (occ == 5'd0);
          end
        end
        ST_DRAIN: begin
          clear      = 1'b1;
          end_nobeat = last_seen || (accept && bus.in_last);
        end
        default: ;
      endcase
    end
    push = accept && !clear && (state == ST_LEN || state == ST_BODY)
           && !(first_pay && bus.msg_count == 16'd0);
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (4'(i) < beat_n) beat_data[8*i +: 8] = head[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hdr_cnt    <= '0;
      first_pay  <= 1'b0;
      last_seen  <= 1'b0;
      first_beat <= 1'b0;
      done_pend  <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      rem        <= '0;
      idx        <= '0;
      msg_valid  <= 1'b0;
      msg_sop    <= 1'b0;
      msg_eop    <= 1'b0;
      msg_nbytes <= '0;
      msg_data   <= '0;
      msg_len    <= '0;
      msg_idx    <= '0;
      err_trunc  <= 1'b0;
      err_len    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      msg_valid  <= beat;
      msg_sop    <= beat && first_beat;
      msg_eop    <= beat && beat_eop;
      msg_nbytes <= beat ? beat_n : 4'd0;
      msg_data   <= beat ? beat_data : 64'd0;
      if (beat) begin
        msg_len <= len_q;
        msg_idx <= idx;
      end
      err_trunc  <= trunc;
      err_len    <= parse && bad_len;
      // A final flush beat delays frame_done by one cycle so it follows the beat.
      frame_done <= end_nobeat || done_pend;
      done_pend  <= end_beat;

      if (start) begin
        state     <= bus.in_last ? ST_IDLE : ST_HDR;
        hdr_cnt   <= 8'd1;
        first_pay <= 1'b0;
        last_seen <= 1'b0;
        idx       <= '0;
      end else begin
        if (accept && bus.in_last && (state == ST_LEN || state == ST_BODY)) last_seen <= 1'b1;
        case (state)
          ST_HDR: begin
            if (accept) begin
              hdr_cnt <= hdr_cnt + 8'd1;
              if (bus.in_last) begin
                state <= ST_IDLE;
              end else if (hdr_cnt == HDR_LAST) begin
                state     <= ST_LEN;
                first_pay <= 1'b1;
              end
            end
          end
          ST_LEN: begin
            if (accept && first_pay) begin
              first_pay <= 1'b0;
              cnt_q     <= bus.msg_count;
              if (bus.msg_count == 16'd0) state <= ST_DRAIN;
            end
            if (end_nobeat) begin
              state     <= ST_IDLE;
              last_seen <= 1'b0;
            end else if (parse) begin
              len_q      <= pfx;
              rem        <= pfx;
              first_beat <= 1'b1;
              state      <= bad_len ? ST_DRAIN : ST_BODY;
            end
          end
          ST_BODY: begin
            if (beat || end_nobeat) begin
              rem        <= rem - {12'd0, beat_n};
              first_beat <= 1'b0;
              if (trunc) begin
                state     <= ST_IDLE;
                last_seen <= 1'b0;
              end else if (beat_eop) begin
                idx   <= idx + 16'd1;
                state <= (idx == cnt_q - 16'd1) ? ST_DRAIN : ST_LEN;
              end
            end
          end
          ST_DRAIN: begin
            if (end_nobeat) begin
              state     <= ST_IDLE;
              last_seen <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_itch_msg_framer.sv
// Directed bench for itch_msg_framer: expected beats are queued as frames are sent
// and a negedge monitor pops and compares them as the framer emits.
module tb_itch_msg_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itch_msg_framer_if bus ();

  logic        msg_valid, msg_sop, msg_eop, err_trunc, err_len, frame_done;
  logic [3:0]  msg_nbytes;
  logic [63:0] msg_data;
  logic [15:0] msg_len, msg_idx;

  itch_msg_framer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .msg_valid  (msg_valid),
    .msg_sop    (msg_sop),
    .msg_eop    (msg_eop),
    .msg_nbytes (msg_nbytes),
    .msg_data   (msg_data),
    .msg_len    (msg_len),
    .msg_idx    (msg_idx),
    .err_trunc  (err_trunc),
    .err_len    (err_len),
    .frame_done (frame_done)
  );

  typedef struct {
    logic        sop;
    logic        eop;
    logic [3:0]  n;
    logic [63:0] data;
    logic [15:0] len;
    logic [15:0] idx;
    logic        trunc;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pay[$];
  int n_checks = 0, n_fail = 0;
  int cnt_done = 0, cnt_len = 0, cnt_trunc = 0, cnt_low = 0;
  int snap_done, snap_len, snap_trunc, snap_low;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endfunction

  function automatic void expect_beat(logic sop, logic eop, logic [3:0] n, logic [63:0] d,
                                      logic [15:0] len, logic [15:0] idx, logic trunc);
    beat_t b;
    b.sop = sop; b.eop = eop; b.n = n; b.data = d; b.len = len; b.idx = idx; b.trunc = trunc;
    exp_q.push_back(b);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done) cnt_done++;
        if (err_len) cnt_len++;
        if (err_trunc) cnt_trunc++;
        if (!bus.in_ready) cnt_low++;
        if (msg_valid) begin
          chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_sop", 64'(msg_sop), 64'(e.sop));
            chk("beat_eop", 64'(msg_eop), 64'(e.eop));
            chk("beat_nbytes", 64'(msg_nbytes), 64'(e.n));
            chk("beat_data", msg_data, e.data);
            chk("beat_len", 64'(msg_len), 64'(e.len));
            chk("beat_idx", 64'(msg_idx), 64'(e.idx));
            chk("beat_err_trunc", 64'(err_trunc), 64'(e.trunc));
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic send_word(input logic sop, input logic last, input logic [3:0] nb,
                           input logic [63:0] d, input logic [15:0] mc);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_sop = sop; bus.in_last = last;
    bus.in_nbytes = nb; bus.in_data = d; bus.msg_count = mc;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] mc, input logic with_last);
    int nw;
    int cnt;
    logic [63:0] d;
    @(posedge clk);
    #1;
    for (int w = 0; w < 8; w++) send_word(w == 0, 1'b0, 4'd8, 64'h0101010101010101 * 64'(w + 1), mc);
    nw = (pay.size() + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      cnt = 0;
      for (int b = 0; b < 8; b++) begin
        if (w * 8 + b < pay.size()) begin
          d[8*b +: 8] = pay[w * 8 + b];
          cnt++;
        end
      end
      send_word(1'b0, with_last && (w == nw - 1), 4'(cnt), d, mc);
    end
  endtask

  task automatic begin_test();
    snap_done = cnt_done; snap_len = cnt_len; snap_trunc = cnt_trunc; snap_low = cnt_low;
  endtask

  task automatic end_test(input string t, input int e_done, input int e_len, input int e_trunc);
    repeat (30) @(negedge clk);
    chk($sformatf("%s_beats_outstanding", t), 64'(exp_q.size()), 64'd0);
    chk($sformatf("%s_frame_done", t), 64'(cnt_done - snap_done), 64'(e_done));
    chk($sformatf("%s_err_len", t), 64'(cnt_len - snap_len), 64'(e_len));
    chk($sformatf("%s_err_trunc", t), 64'(cnt_trunc - snap_trunc), 64'(e_trunc));
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_last = 1'b0;
    bus.in_nbytes = 4'd0; bus.in_data = '0; bus.msg_count = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_msg_valid", 64'(msg_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_err", 64'({err_trunc, err_len}), 64'd0);
    chk("reset_msg_data", msg_data, 64'd0);
    rst = 1'b0;

    // single 6-byte message
    begin_test();
    pay = {8'h00, 8'h06, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    expect_beat(1, 1, 4'd6, 64'h0000_4645_4443_4241, 16'd6, 16'd0, 0);
    send_frame(16'd1, 1'b1);
    end_test("t1", 1, 0, 0);

    // len 3 then len 12, with backpressure
    begin_test();
    pay = {8'h00, 8'h03, 8'h11, 8'h12, 8'h13, 8'h00, 8'h0C,
           8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C};
    expect_beat(1, 1, 4'd3, 64'h0000_0000_0013_1211, 16'd3, 16'd0, 0);
    expect_beat(1, 0, 4'd8, 64'h2827_2625_2423_2221, 16'd12, 16'd1, 0);
    expect_beat(0, 1, 4'd4, 64'h0000_0000_2C2B_2A29, 16'd12, 16'd1, 0);
    send_frame(16'd2, 1'b1);
    end_test("t2", 1, 0, 0);
    chk("t2_in_ready_dropped", 64'(cnt_low - snap_low >= 1), 64'd1);

    // heartbeat: messageCount 0, 10-word frame
    begin_test();
    pay = {8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    send_frame(16'd0, 1'b1);
    end_test("t3", 1, 0, 0);
    chk("t3_in_ready_low_cycles", 64'(cnt_low - snap_low), 64'd0);

    // messageCount 1 with two messages: second dropped
    begin_test();
    pay = {8'h00, 8'h02, 8'h51, 8'h52, 8'h00, 8'h03, 8'h61, 8'h62, 8'h63};
    expect_beat(1, 1, 4'd2, 64'h0000_0000_0000_5251, 16'd2, 16'd0, 0);
    send_frame(16'd1, 1'b1);
    end_test("t4", 1, 0, 0);

    // zero-length prefix
    begin_test();
    pay = {8'h00, 8'h00, 8'hAA, 8'hBB};
    send_frame(16'd1, 1'b1);
    end_test("t5a", 1, 1, 0);

    // 1024 > max length
    begin_test();
    pay = {8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(16'd1, 1'b1);
    end_test("t5b", 1, 1, 0);

    // frame ends 5 bytes into a 20-byte message
    begin_test();
    pay = {8'h00, 8'h14, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    expect_beat(1, 1, 4'd5, 64'h0000_0075_7473_7271, 16'd20, 16'd0, 1);
    send_frame(16'd1, 1'b1);
    end_test("t6", 1, 0, 1);

    // async reset in the middle of a message
    begin_test();
    pay = {8'h00, 8'h14, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86,
           8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E};
    expect_beat(1, 0, 4'd8, 64'h8887_8685_8483_8281, 16'd20, 16'd0, 0);
    send_frame(16'd1, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_msg_valid", 64'(msg_valid), 64'd0);
    chk("rst_mid_msg_len", 64'(msg_len), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mid_flags", 64'({msg_sop, msg_eop, err_trunc, frame_done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    end_test("t7", 0, 0, 0);

    // recovery after reset
    begin_test();
    pay = {8'h00, 8'h06, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    expect_beat(1, 1, 4'd6, 64'h0000_4645_4443_4241, 16'd6, 16'd0, 0);
    send_frame(16'd1, 1'b1);
    end_test("t8", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
